// File: rtl/sr_tap_line.sv
// Tapped delay line with runtime-selectable delayed output, a parallel window of the
// newest samples and a fill tracker. Optional edge-pad mode: define SR_EDGE_REPLICATE_EN.
module sr_tap_line #(
  parameter int unsigned BIT   = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAPS  = 4,
  parameter int unsigned LW    = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clr,
  input  logic                en,
  input  logic [BIT-1:0]      din,
  input  logic [LW-1:0]       len,
  output logic [BIT-1:0]      dout,
  output logic                dout_vld,
  output logic [BIT*TAPS-1:0] win,
  output logic                win_vld,
  output logic [LW-1:0]       fill
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] TAPS_L  = LW'(TAPS);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  logic [BIT-1:0] s_q    [DEPTH];
  logic [BIT-1:0] s_base [DEPTH];
  logic [BIT-1:0] s_nxt  [DEPTH];
  logic [LW-1:0]  fill_q;
  logic [LW-1:0]  fill_base;
  logic [LW-1:0]  fill_nxt;
  logic [LW-1:0]  len_eff;

  // Next state: optional flush first, then accept din on top of the flushed line.
  always_comb begin
    s_base    = s_q;
    fill_base = fill_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) s_base[i] = '0;
      fill_base = '0;
    end
    s_nxt    = s_base;
    fill_nxt = fill_base;
    if (en) begin
      s_nxt[0] = din;
      for (int i = 1; i < DEPTH; i++) s_nxt[i] = s_base[i-1];
      fill_nxt = (fill_base >= DEPTH_L) ? DEPTH_L : fill_base + ONE_L;
`ifdef SR_EDGE_REPLICATE_EN
      // Border padding: the first sample of a row is replicated into every stage.
      if (fill_base == '0) begin
        for (int i = 0; i < DEPTH; i++) s_nxt[i] = din;
        fill_nxt = DEPTH_L;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) s_q[i] <= '0;
      fill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) s_q[i] <= s_nxt[i];
      fill_q <= fill_nxt;
    end
  end

  // Delay selection clamps to 1..DEPTH so dout always addresses a real stage.
  always_comb begin
    len_eff = len;
    if (len == '0)          len_eff = ONE_L;
    else if (len > DEPTH_L) len_eff = DEPTH_L;
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < TAPS; k++) win[BIT*k +: BIT] = s_q[k];
  end

  assign dout     = s_q[AW'(len_eff - ONE_L)];
  assign dout_vld = (fill_q >= len_eff);
  assign win_vld  = (fill_q >= TAPS_L);
  assign fill     = fill_q;

endmodule

// File: tb/tb_sr_tap_line.sv
// Directed self-checking bench for sr_tap_line (BIT=8, DEPTH=16, TAPS=4, LW=5).
module tb_sr_tap_line;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clr;
  logic        en;
  logic [7:0]  din;
  logic [4:0]  len;
  logic [7:0]  dout;
  logic        dout_vld;
  logic [31:0] win;
  logic        win_vld;
  logic [4:0]  fill;

  int total = 0;
  int bad   = 0;

  sr_tap_line #(.BIT(8), .DEPTH(16), .TAPS(4), .LW(5)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .en(en), .din(din), .len(len),
    .dout(dout), .dout_vld(dout_vld), .win(win), .win_vld(win_vld), .fill(fill)
  );

  always #5 CLK = ~CLK;

  // Apply one cycle of inputs and settle just after the rising edge.
  task automatic step(input logic c, input logic e, input logic [7:0] d);
    clr = c; en = e; din = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; len = 5'd1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hAA);
    total++; if (fill !== 5'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_dout_vld got=%b exp=0", dout_vld); end
    total++; if (win !== 32'h0) begin bad++; $display("FAIL reset_win got=%h exp=00000000", win); end
    total++; if (win_vld !== 1'b0) begin bad++; $display("FAIL reset_win_vld got=%b exp=0", win_vld); end
    RST = 1'b1;
  endtask

  task automatic test_delay();
    len = 5'd3;
    step(1'b0, 1'b1, 8'd1);
    step(1'b0, 1'b1, 8'd2);
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL delay_vld_e2 got=%b exp=0", dout_vld); end
    step(1'b0, 1'b1, 8'd3);
    total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL delay_vld_e3 got=%b exp=1", dout_vld); end
    total++; if (dout !== 8'd1) begin bad++; $display("FAIL delay_dout_e3 got=%0d exp=1", dout); end
    step(1'b0, 1'b1, 8'd4);
    total++; if (dout !== 8'd2) begin bad++; $display("FAIL delay_dout_e4 got=%0d exp=2", dout); end
    step(1'b0, 1'b1, 8'd5);
    total++; if (dout !== 8'd3) begin bad++; $display("FAIL delay_dout_e5 got=%0d exp=3", dout); end
    total++; if (fill !== 5'd5) begin bad++; $display("FAIL delay_fill got=%0d exp=5", fill); end
  endtask

  task automatic test_window();
    step(1'b1, 1'b0, 8'd0);
    total++; if (fill !== 5'd0) begin bad++; $display("FAIL win_flush_fill got=%0d exp=0", fill); end
    step(1'b0, 1'b1, 8'd10);
    step(1'b0, 1'b0, 8'd0);
    total++; if (fill !== 5'd1) begin bad++; $display("FAIL win_stall_fill got=%0d exp=1", fill); end
    step(1'b0, 1'b1, 8'd20);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd30);
    step(1'b0, 1'b0, 8'd0);
    total++; if (win_vld !== 1'b0) begin bad++; $display("FAIL win_vld_3 got=%b exp=0", win_vld); end
    total++; if (fill !== 5'd3) begin bad++; $display("FAIL win_fill_3 got=%0d exp=3", fill); end
    step(1'b0, 1'b1, 8'd40);
    total++; if (win_vld !== 1'b1) begin bad++; $display("FAIL win_vld_4 got=%b exp=1", win_vld); end
    total++; if (win !== 32'h0A141E28) begin bad++; $display("FAIL win_data got=%h exp=0a141e28", win); end
    step(1'b0, 1'b0, 8'd99);
    step(1'b0, 1'b0, 8'd99);
    total++; if (win !== 32'h0A141E28) begin bad++; $display("FAIL win_stall_data got=%h exp=0a141e28", win); end
    total++; if (win_vld !== 1'b1) begin bad++; $display("FAIL win_stall_vld got=%b exp=1", win_vld); end
    total++; if (fill !== 5'd4) begin bad++; $display("FAIL win_stall_fill4 got=%0d exp=4", fill); end
  endtask

  task automatic test_flush();
    len = 5'd1;
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i + 1));
    total++; if (fill !== 5'd16) begin bad++; $display("FAIL flush_full got=%0d exp=16", fill); end
    step(1'b1, 1'b1, 8'd7);
    total++; if (fill !== 5'd1) begin bad++; $display("FAIL flush_en_fill got=%0d exp=1", fill); end
    total++; if (win !== 32'h00000007) begin bad++; $display("FAIL flush_en_win got=%h exp=00000007", win); end
    total++; if (win_vld !== 1'b0) begin bad++; $display("FAIL flush_en_win_vld got=%b exp=0", win_vld); end
    total++; if (dout !== 8'd7 || dout_vld !== 1'b1) begin bad++; $display("FAIL flush_en_dout got=%0d/%b exp=7/1", dout, dout_vld); end
    len = 5'd2; #1;
    total++; if (dout !== 8'd0 || dout_vld !== 1'b0) begin bad++; $display("FAIL flush_s1_zero got=%0d/%b exp=0/0", dout, dout_vld); end
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 8'(i));
    total++; if (fill !== 5'd15) begin bad++; $display("FAIL flush_fill15 got=%0d exp=15", fill); end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(i));
    total++; if (fill !== 5'd16) begin bad++; $display("FAIL flush_sat got=%0d exp=16", fill); end
    step(1'b1, 1'b0, 8'd0);
    total++; if (fill !== 5'd0 || win !== 32'h0) begin bad++; $display("FAIL flush_clr got=%0d/%h exp=0/00000000", fill, win); end
  endtask

  task automatic test_len();
    len = 5'd0;
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'h55);
    total++; if (dout !== 8'h55 || dout_vld !== 1'b1) begin bad++; $display("FAIL len0 got=%h/%b exp=55/1", dout, dout_vld); end
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'(8'h50 + i));
    len = 5'd31; #1;
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL len31_vld15 got=%b exp=0", dout_vld); end
    step(1'b0, 1'b1, 8'h5F);
    total++; if (dout !== 8'h50 || dout_vld !== 1'b1) begin bad++; $display("FAIL len31 got=%h/%b exp=50/1", dout, dout_vld); end
    len = 5'd0; #1;
    total++; if (dout !== 8'h5F) begin bad++; $display("FAIL len0_full got=%h exp=5f", dout); end
    len = 5'd17; #1;
    total++; if (dout !== 8'h50) begin bad++; $display("FAIL len17 got=%h exp=50", dout); end
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd1);
    step(1'b0, 1'b1, 8'd2);
    step(1'b0, 1'b1, 8'd3);
    len = 5'd2; #1;
    total++; if (dout !== 8'd2 || dout_vld !== 1'b1) begin bad++; $display("FAIL len2 got=%0d/%b exp=2/1", dout, dout_vld); end
    len = 5'd5; #1;
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL len5_vld got=%b exp=0", dout_vld); end
    step(1'b0, 1'b0, 8'd0);
    len = 5'd3; #1;
    total++; if (fill !== 5'd3 || dout !== 8'd1 || dout_vld !== 1'b1) begin bad++; $display("FAIL len_undisturbed got=%0d/%0d/%b exp=3/1/1", fill, dout, dout_vld); end
  endtask

  task automatic test_mid_reset();
    RST = 1'b0;
    step(1'b0, 1'b1, 8'h77);
    total++; if (fill !== 5'd0 || win !== 32'h0 || dout_vld !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%h/%b exp=0/00000000/0", fill, win, dout_vld); end
    RST = 1'b1;
  endtask

  task automatic test_edge();
    len = 5'd4;
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd9);
`ifdef SR_EDGE_REPLICATE_EN
    total++; if (win !== 32'h09090909 || win_vld !== 1'b1) begin bad++; $display("FAIL edge_win got=%h/%b exp=09090909/1", win, win_vld); end
    total++; if (dout !== 8'd9 || dout_vld !== 1'b1) begin bad++; $display("FAIL edge_dout got=%0d/%b exp=9/1", dout, dout_vld); end
    total++; if (fill !== 5'd16) begin bad++; $display("FAIL edge_fill got=%0d exp=16", fill); end
`else
    total++; if (win !== 32'h00000009 || win_vld !== 1'b0) begin bad++; $display("FAIL edge_win got=%h/%b exp=00000009/0", win, win_vld); end
    total++; if (dout !== 8'd0 || dout_vld !== 1'b0) begin bad++; $display("FAIL edge_dout got=%0d/%b exp=0/0", dout, dout_vld); end
    total++; if (fill !== 5'd1) begin bad++; $display("FAIL edge_fill got=%0d exp=1", fill); end
`endif
  endtask

  initial begin
    RST = 1'b0; clr = 1'b0; en = 1'b0; din = '0; len = 5'd1;
    test_reset();
    test_delay();
    test_window();
    test_flush();
    test_len();
    test_mid_reset();
    test_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
